// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pkg
// Description : Shared pixel/window types and coordinate-width helper for the
//               convolution pipeline (window_generator, kernel_convolution).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int c_kernel_size_def = 3;
  localparam int c_word_size_def   = 16;
  localparam int c_img_width_def   = 640;
  localparam int c_img_height_def  = 480;

  // Width of a coordinate counter able to hold 0..n-1 (at least one bit).
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int c_col_w_def = coord_w(c_img_width_def);
  localparam int c_row_w_def = coord_w(c_img_height_def);

  typedef logic signed [c_word_size_def-1:0] pixel_t;
  typedef pixel_t [c_kernel_size_def-1:0][c_kernel_size_def-1:0] window_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/window_generator_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One image line of pixel storage, addressed by column. The read
//               port returns the old content of the addressed column while the
//               same edge writes the new pixel, so a chain of these delays a
//               column by exactly one line per stage. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Old value is visible combinationally until the edge overwrites it.
  assign rdata_o = mem_q[addr_i];

  // Column write on every accepted pixel.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule : line_buffer
`default_nettype wire

// File: rtl/window_generator.sv
`default_nettype none
// ============================================================================
// Module      : window_generator
// Description : Turns a raster-order pixel stream into KERNEL_SIZE x
//               KERNEL_SIZE windows (no padding) with centre coordinates.
//               KERNEL_SIZE-1 line buffers supply the older rows of the
//               incoming column; a register window shifts left per pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module window_generator
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int WORD_SIZE   = 16,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic signed [WORD_SIZE-1:0]                          pix_in,
  input  logic                                                 pix_valid,
  input  logic                                                 pix_sof,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] win_out,
  output logic                                                 win_valid,
  output logic [coord_w(IMG_WIDTH)-1:0]                        win_x,
  output logic [coord_w(IMG_HEIGHT)-1:0]                       win_y,
  output logic                                                 frame_done
);

  localparam int c_cw   = coord_w(IMG_WIDTH);
  localparam int c_rw   = coord_w(IMG_HEIGHT);
  localparam int c_half = (KERNEL_SIZE - 1) / 2;

  localparam logic [c_cw-1:0] c_col_last  = c_cw'(IMG_WIDTH - 1);
  localparam logic [c_rw-1:0] c_row_last  = c_rw'(IMG_HEIGHT - 1);
  localparam logic [c_cw-1:0] c_col_first = c_cw'(KERNEL_SIZE - 1);
  localparam logic [c_rw-1:0] c_row_first = c_rw'(KERNEL_SIZE - 1);
  localparam logic [c_cw-1:0] c_col_half  = c_cw'(c_half);
  localparam logic [c_rw-1:0] c_row_half  = c_rw'(c_half);

  logic [c_cw-1:0] col_q, col_d, w_col;
  logic [c_rw-1:0] row_q, row_d, w_row;
  logic            w_win_hit;
  logic            w_frame_end;

  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] win_q, win_d;
  logic [KERNEL_SIZE-1:0][WORD_SIZE-1:0]                  w_colvec;
  logic [KERNEL_SIZE-2:0][WORD_SIZE-1:0]                  w_lb_rd;
  logic [KERNEL_SIZE-2:0][WORD_SIZE-1:0]                  w_lb_wr;

  logic            win_valid_q;
  logic            frame_done_q;
  logic [c_cw-1:0] win_x_q;
  logic [c_rw-1:0] win_y_q;

  // A start-of-frame pixel overrides the counters and is placed at (0,0).
  assign w_col = pix_sof ? '0 : col_q;
  assign w_row = pix_sof ? '0 : row_q;

  assign w_win_hit   = pix_valid && (w_col >= c_col_first) && (w_row >= c_row_first);
  assign w_frame_end = pix_valid && (w_col == c_col_last) && (w_row == c_row_last);

  // Line buffer chain: stage 0 takes the new pixel, each later stage takes the
  // value evicted from the stage before it. Newest row sits at the bottom.
  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign w_lb_wr[k] = pix_in;
    end else begin : g_chain
      assign w_lb_wr[k] = w_lb_rd[k-1];
    end

    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (WORD_SIZE),
      .AW    (c_cw)
    ) u_line_buffer (
      .clk     (clk),
      .we_i    (pix_valid),
      .addr_i  (w_col),
      .wdata_i (w_lb_wr[k]),
      .rdata_o (w_lb_rd[k])
    );

    assign w_colvec[KERNEL_SIZE-2-k] = w_lb_rd[k];
  end

  assign w_colvec[KERNEL_SIZE-1] = pix_in;

  // Raster position advance and window left-shift for the accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (pix_valid) begin
      if (w_col == c_col_last) begin
        col_d = '0;
        row_d = (w_row == c_row_last) ? '0 : w_row + 1'b1;
      end else begin
        col_d = w_col + 1'b1;
        row_d = w_row;
      end
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
          win_d[r][j] = win_q[r][j+1];
        end
        win_d[r][KERNEL_SIZE-1] = w_colvec[r];
      end
    end
  end

  // State and registered outputs; flags are single-cycle and need an accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= w_win_hit;
      frame_done_q <= w_frame_end;
      if (w_win_hit) begin
        win_x_q <= w_col - c_col_half;
        win_y_q <= w_row - c_row_half;
      end
    end
  end

  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;

endmodule : window_generator
`default_nettype wire
